rom_uart_dump: RTL and testbench

ROM_UART_DUMP -- requirements
Module: rom_uart_dump

---
 rtl/rom_uart_dump.sv | 170 +++++++++++++++++
 tb/tb_rom_uart_dump.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_uart_dump.sv
// Streams ROM[ADDR_FIRST..ADDR_LAST] out of a UART, one 8N1 frame per byte (8E1 when
// ROM_UART_DUMP_PARITY_EN is defined). FSM state is exported on state_dbg.
module rom_uart_dump #(
  parameter int BAUD_DIV   = 217,
  parameter int ADDR_FIRST = 0,
  parameter int ADDR_LAST  = 31
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  output logic [4:0] rom_addr,
  input  logic [7:0] rom_data,
  output logic       uart_tx,
  output logic       busy,
  output logic       done,
  output logic [2:0] state_dbg
);

  // Handshake: start is a one-cycle request sampled only in IDLE (ignored while busy,
  // never queued); done is a one-cycle pulse in the same cycle busy falls.

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_ADDR   = 3'd1,
    S_WAIT   = 3'd2,
    S_LATCH  = 3'd3,
    S_START  = 3'd4,
    S_DATA   = 3'd5,
`ifdef ROM_UART_DUMP_PARITY_EN
    S_PARITY = 3'd6,
`endif
    S_STOP   = 3'd7
  } state_t;

  localparam logic [9:0] BAUD_LAST = 10'(BAUD_DIV - 1);
  localparam logic [4:0] A_FIRST   = 5'(ADDR_FIRST);
  localparam logic [4:0] A_LAST    = 5'(ADDR_LAST);

  state_t     state, state_d;
  logic [9:0] baud_cnt, baud_cnt_d;
  logic [2:0] bit_idx, bit_idx_d;
  logic [7:0] shreg, shreg_d;
  logic [4:0] rom_addr_d;
  logic       tx_d, busy_d, done_d;
  logic       bit_end;
`ifdef ROM_UART_DUMP_PARITY_EN
  logic       parity, parity_d;
`endif

  assign bit_end   = (baud_cnt == BAUD_LAST);
  assign state_dbg = state;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      shreg    <= '0;
      rom_addr <= '0;
      uart_tx  <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
`ifdef ROM_UART_DUMP_PARITY_EN
      parity   <= 1'b0;
`endif
    end else begin
      state    <= state_d;
      baud_cnt <= baud_cnt_d;
      bit_idx  <= bit_idx_d;
      shreg    <= shreg_d;
      rom_addr <= rom_addr_d;
      uart_tx  <= tx_d;
      busy     <= busy_d;
      done     <= done_d;
`ifdef ROM_UART_DUMP_PARITY_EN
      parity   <= parity_d;
`endif
    end
  end

  always_comb begin
    state_d    = state;
    baud_cnt_d = '0;
    bit_idx_d  = bit_idx;
    shreg_d    = shreg;
    rom_addr_d = rom_addr;
    busy_d     = busy;
    done_d     = 1'b0;
    tx_d       = 1'b1;
`ifdef ROM_UART_DUMP_PARITY_EN
    parity_d   = parity;
`endif

    // Baud counter runs only inside a frame and wraps at each bit boundary.
    if (state == S_START || state == S_DATA || state == S_STOP
`ifdef ROM_UART_DUMP_PARITY_EN
        || state == S_PARITY
`endif
       ) begin
      baud_cnt_d = bit_end ? '0 : baud_cnt + 10'd1;
    end

    case (state)
      S_IDLE: begin
        if (start) begin
          state_d    = S_ADDR;
          rom_addr_d = A_FIRST;
          busy_d     = 1'b1;
        end
      end
      S_ADDR:  state_d = S_WAIT;
      S_WAIT:  state_d = S_LATCH;
      S_LATCH: begin
        // Two edges have passed since rom_addr moved, so the ROM q is now valid.
        shreg_d   = rom_data;
        bit_idx_d = '0;
        state_d   = S_START;
`ifdef ROM_UART_DUMP_PARITY_EN
        parity_d  = ^rom_data;
`endif
      end
      S_START: begin
        if (bit_end) state_d = S_DATA;
      end
      S_DATA: begin
        if (bit_end) begin
          if (bit_idx == 3'd7) begin
`ifdef ROM_UART_DUMP_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_idx_d = bit_idx + 3'd1;
            shreg_d   = {1'b0, shreg[7:1]};
          end
        end
      end
`ifdef ROM_UART_DUMP_PARITY_EN
      S_PARITY: begin
        if (bit_end) state_d = S_STOP;
      end
`endif
      S_STOP: begin
        if (bit_end) begin
          if (rom_addr != A_LAST) begin
            rom_addr_d = rom_addr + 5'd1;
            state_d    = S_ADDR;
          end else begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // uart_tx is registered from the next state so the line lines up with the FSM.
    case (state_d)
      S_START:  tx_d = 1'b0;
      S_DATA:   tx_d = shreg_d[0];
`ifdef ROM_UART_DUMP_PARITY_EN
      S_PARITY: tx_d = parity_d;
`endif
      default:  tx_d = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_rom_uart_dump.sv
// Bench for rom_uart_dump: a single-byte instance (addr 3) and a full-sweep instance
// (addr 0..31), both at BAUD_DIV=4, with UART frame monitors feeding a scoreboard.
module tb_rom_uart_dump;

  localparam int B = 4;
`ifdef ROM_UART_DUMP_PARITY_EN
  localparam int F = 11;
`else
  localparam int F = 10;
`endif
  localparam int FRAME = 3 + F * B;
  localparam int N_FULL = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start_one, start_full;
  logic [4:0] addr_one, addr_full;
  logic [7:0] q_one, q_full, r1_one, r1_full;
  logic tx_one, tx_full, busy_one, busy_full, done_one, done_full;
  logic [2:0] st_one, st_full;

  always #5 clk = ~clk;

  rom_uart_dump #(.BAUD_DIV(B), .ADDR_FIRST(3), .ADDR_LAST(3)) dut_one (
    .clk(clk), .rst_n(rst_n), .start(start_one), .rom_addr(addr_one), .rom_data(q_one),
    .uart_tx(tx_one), .busy(busy_one), .done(done_one), .state_dbg(st_one)
  );

  rom_uart_dump #(.BAUD_DIV(B), .ADDR_FIRST(0), .ADDR_LAST(31)) dut_full (
    .clk(clk), .rst_n(rst_n), .start(start_full), .rom_addr(addr_full), .rom_data(q_full),
    .uart_tx(tx_full), .busy(busy_full), .done(done_full), .state_dbg(st_full)
  );

  // Synchronous ROMs with two-stage read latency.
  logic [7:0] rom_one [32];
  logic [7:0] rom_full [32];
  always @(posedge clk) begin
    r1_one  <= rom_one[addr_one];
    q_one   <= r1_one;
    r1_full <= rom_full[addr_full];
    q_full  <= r1_full;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int done_cnt_full = 0;
  always @(negedge clk) if (done_full === 1'b1) done_cnt_full <= done_cnt_full + 1;

  int checks = 0;
  int errors = 0;
  logic [7:0] exp_q_one [$];
  logic [7:0] exp_q_full [$];
  int last_stop_full = -1;
  int max_gap_full = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic tx_of(input int id);
    return (id == 1) ? tx_full : tx_one;
  endfunction

  function automatic logic done_of(input int id);
    return (id == 1) ? done_full : done_one;
  endfunction

  // Frame monitor: samples every negedge, checks each bit holds for exactly B cycles.
  task automatic uart_mon(input int id);
    logic [10:0] bits;
    logic stable, aborted, s;
    logic [7:0] exp_b;
    string pfx;
    pfx = (id == 1) ? "full" : "one";
    forever begin
      @(negedge clk);
      if (rst_n && tx_of(id) === 1'b0) begin
        if (id == 1 && last_stop_full >= 0 && (cyc - last_stop_full - 1) > max_gap_full)
          max_gap_full = cyc - last_stop_full - 1;
        bits = '1;
        stable = 1'b1;
        aborted = 1'b0;
        for (int i = 0; i < F * B; i++) begin
          if (i > 0) @(negedge clk);
          if (!rst_n) begin
            aborted = 1'b1;
            break;
          end
          s = tx_of(id);
          if (i % B == 0) bits[i / B] = s;
          else if (s !== bits[i / B]) stable = 1'b0;
        end
        if (!aborted) begin
          check({pfx, "_bit_width"}, 32'(stable), 32'd1);
          check({pfx, "_stop_bit"}, 32'(bits[F-1]), 32'd1);
          if ((id == 1 && exp_q_full.size() == 0) || (id == 0 && exp_q_one.size() == 0)) begin
            check({pfx, "_unexpected_frame"}, 32'(bits[8:1]), 32'hFFFF_FFFF);
          end else begin
            exp_b = (id == 1) ? exp_q_full.pop_front() : exp_q_one.pop_front();
            check({pfx, "_data"}, 32'(bits[8:1]), 32'(exp_b));
`ifdef ROM_UART_DUMP_PARITY_EN
            check({pfx, "_parity"}, 32'(bits[9]), 32'(^exp_b));
`endif
          end
          if (id == 1) last_stop_full = cyc;
        end else if (id == 1) begin
          last_stop_full = -1;
        end
      end
    end
  endtask

  // Raises start at the current time (caller sits on a negedge), clears it one cycle later.
  task automatic pulse_start(input int id, output int t);
    t = cyc;
    if (id == 1) start_full = 1'b1; else start_one = 1'b1;
    @(negedge clk);
    start_full = 1'b0;
    start_one = 1'b0;
  endtask

  task automatic wait_done(input int id, input int budget, output int t);
    t = -1;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (done_of(id) === 1'b1) begin
        t = cyc;
        return;
      end
    end
    check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic push_full();
    for (int i = 0; i < N_FULL; i++) exp_q_full.push_back(rom_full[i]);
  endtask

  int t0, t1, td, dc0;

  initial begin
    start_one = 1'b0;
    start_full = 1'b0;
    for (int i = 0; i < 32; i++) begin
      rom_one[i]  = 8'($urandom_range(0, 255));
      rom_full[i] = 8'(i);
    end
    rom_one[3] = 8'h55;
`ifdef ROM_UART_DUMP_PARITY_EN
    rom_full[0] = 8'h07;
`endif
    fork
      uart_mon(0);
      uart_mon(1);
    join_none

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx_one", 32'(tx_one), 32'd1);
    check("rst_tx_full", 32'(tx_full), 32'd1);
    check("rst_busy", 32'(busy_full), 32'd0);
    check("rst_done", 32'(done_full), 32'd0);
    check("rst_addr_one", 32'(addr_one), 32'd0);
    check("rst_addr_full", 32'(addr_full), 32'd0);
    check("rst_state", 32'(st_full), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("no_start_after_rst", 32'(busy_full), 32'd0);

    // Single byte 0x55 at address 3
    exp_q_one.push_back(rom_one[3]);
    pulse_start(0, t0);
    check("one_busy", 32'(busy_one), 32'd1);
    wait_done(0, 200, td);
    check("one_latency", 32'(td - t0), 32'(FRAME + 1));
    check("one_busy_at_done", 32'(busy_one), 32'd0);
    check("one_addr", 32'(addr_one), 32'd3);
    @(negedge clk);
    check("one_done_pulse", 32'(done_one), 32'd0);
    repeat (4) @(negedge clk);
    check("one_addr_hold", 32'(addr_one), 32'd3);
    check("one_queue_empty", 32'(exp_q_one.size()), 32'd0);

    // Full sweep with a second start mid-dump
    push_full();
    dc0 = done_cnt_full;
    pulse_start(1, t0);
    repeat (100) @(negedge clk);
    check("full_busy", 32'(busy_full), 32'd1);
    pulse_start(1, t1);
    wait_done(1, N_FULL * FRAME + 100, td);
    check("full_latency", 32'(td - t0), 32'(N_FULL * FRAME + 1));
    check("full_busy_at_done", 32'(busy_full), 32'd0);
    check("full_addr_last", 32'(addr_full), 32'd31);
    check("full_queue_empty", 32'(exp_q_full.size()), 32'd0);

    // Back-to-back: restart in the done cycle
    max_gap_full = 0;
    push_full();
    pulse_start(1, t0);
    check("full_done_once", 32'(done_cnt_full - dc0), 32'd1);
    wait_done(1, N_FULL * FRAME + 100, td);
    check("b2b_latency", 32'(td - t0), 32'(N_FULL * FRAME + 1));
    check("b2b_gap_le4", 32'(max_gap_full <= 4), 32'd1);
    check("b2b_queue_empty", 32'(exp_q_full.size()), 32'd0);

    // Reset during data bit 3
    repeat (3) @(negedge clk);
    push_full();
    pulse_start(1, t0);
    while (cyc < t0 + 6 + 4 * B) @(negedge clk);
    check("mid_in_data", 32'(st_full), 32'd5);
    #1 rst_n = 1'b0;
    #1;
    check("mid_rst_tx", 32'(tx_full), 32'd1);
    check("mid_rst_busy", 32'(busy_full), 32'd0);
    check("mid_rst_addr", 32'(addr_full), 32'd0);
    check("mid_rst_done", 32'(done_full), 32'd0);
    exp_q_full.delete();
    @(negedge clk);
    rst_n = 1'b1;
    last_stop_full = -1;
    @(negedge clk);
    check("mid_no_restart", 32'(busy_full), 32'd0);
    push_full();
    pulse_start(1, t0);
    wait_done(1, N_FULL * FRAME + 100, td);
    check("redump_latency", 32'(td - t0), 32'(N_FULL * FRAME + 1));
    check("redump_addr", 32'(addr_full), 32'd31);
    check("redump_queue_empty", 32'(exp_q_full.size()), 32'd0);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got=0 exp=1");
    $fatal(1, "timeout");
  end

endmodule
